// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer computing base^e mod n in the Montgomery
// domain. It drives a Montgomery multiplier through a mul_clr/mul_start/mul_finish handshake.
module mod_exp_ctrl #(
  parameter int W  = 2048,
  parameter int CW = 11
) (
  input  logic           clk,
  input  logic           mul_rst,
  input  logic           exp_start,
  input  logic [W-1:0]   base_m,
  input  logic [W-1:0]   one_m,
  input  logic [W-1:0]   e,
  input  logic [W-1:0]   n,
  output logic           mul_clr,
  output logic           mul_start,
  output logic [W:0]     mul_x,
  output logic [W:0]     mul_y,
  output logic [W-1:0]   mul_n,
  input  logic [W+1:0]   mul_result,
  input  logic           mul_finish,
  output logic [W-1:0]   exp_result,
  output logic           exp_done,
  output logic           exp_busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    NEXT  = 3'd4,
    DONE  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    OP_SQR = 2'd0,
    OP_MUL = 2'd1,
    OP_FIN = 2'd2
  } op_t;

  state_t         state_r;
  state_t         state_nxt_s;
  op_t            op_r;
  logic [W-1:0]   acc_r;
  logic [W-1:0]   base_r;
  logic [W-1:0]   e_r;
  logic [CW-1:0]  idx_r;

  // The multiplier always reduces its result below n, so the two guard bits carry no information.
  logic           mul_result_unused_s;
  assign mul_result_unused_s = ^mul_result[W+1:W];

  // State register
  always_ff @(posedge clk or posedge mul_rst) begin
    if (mul_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE, DONE: begin
        if (exp_start) begin
          state_nxt_s = CLR;
        end else begin
          state_nxt_s = state_r;
        end
      end
      CLR:   state_nxt_s = ISSUE;
      ISSUE: state_nxt_s = WAIT;
      WAIT: begin
        if (mul_finish) begin
          state_nxt_s = NEXT;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      NEXT: begin
        if (op_r == OP_FIN) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = CLR;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Datapath and registered outputs; handshake strobes are decoded from the next state so they align with it
  always_ff @(posedge clk or posedge mul_rst) begin
    if (mul_rst) begin
      mul_clr    <= 1'b1;
      mul_start  <= 1'b0;
      mul_x      <= '0;
      mul_y      <= '0;
      mul_n      <= '0;
      exp_result <= '0;
      exp_done   <= 1'b0;
      exp_busy   <= 1'b0;
      acc_r      <= '0;
      base_r     <= '0;
      e_r        <= '0;
      idx_r      <= '0;
      op_r       <= OP_SQR;
    end else begin
      mul_clr   <= (state_nxt_s == IDLE) || (state_nxt_s == CLR) || (state_nxt_s == DONE);
      mul_start <= (state_nxt_s == ISSUE);
      case (state_r)
        IDLE, DONE: begin
          if (exp_start) begin
            base_r   <= base_m;
            e_r      <= e;
            mul_n    <= n;
            acc_r    <= one_m;
            idx_r    <= CW'(W - 1);
            op_r     <= OP_SQR;
            exp_busy <= 1'b1;
            exp_done <= 1'b0;
          end
        end
        CLR: begin
          mul_x <= {1'b0, acc_r};
          case (op_r)
            OP_SQR:  mul_y <= {1'b0, acc_r};
            OP_MUL:  mul_y <= {1'b0, base_r};
            OP_FIN:  mul_y <= {{W{1'b0}}, 1'b1};
            default: mul_y <= {1'b0, acc_r};
          endcase
        end
        WAIT: begin
          if (mul_finish) begin
            acc_r <= mul_result[W-1:0];
          end
        end
        NEXT: begin
          case (op_r)
            OP_SQR, OP_MUL: begin
              if ((op_r == OP_SQR) && e_r[idx_r]) begin
                op_r <= OP_MUL;
              end else if (idx_r == '0) begin
                op_r <= OP_FIN;
              end else begin
                idx_r <= idx_r - CW'(1);
                op_r  <= OP_SQR;
              end
            end
            OP_FIN: begin
              exp_result <= acc_r;
              exp_busy   <= 1'b0;
              exp_done   <= 1'b1;
            end
            default: op_r <= OP_FIN;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Scoreboarded bench for mod_exp_ctrl with W=8, n=187, base=5, driving a behavioural
// Montgomery multiplier with random completion latency.
module tb_mod_exp_ctrl;

  localparam int W  = 8;
  localparam int CW = 3;

  logic           clk = 1'b0;
  logic           mul_rst;
  logic           exp_start;
  logic [W-1:0]   base_m, one_m, e, n;
  logic           mul_clr, mul_start;
  logic [W:0]     mul_x, mul_y;
  logic [W-1:0]   mul_n;
  logic [W+1:0]   mul_result;
  logic           mul_finish;
  logic [W-1:0]   exp_result;
  logic           exp_done, exp_busy;

  mod_exp_ctrl #(.W(W), .CW(CW)) dut (
    .clk(clk), .mul_rst(mul_rst), .exp_start(exp_start),
    .base_m(base_m), .one_m(one_m), .e(e), .n(n),
    .mul_clr(mul_clr), .mul_start(mul_start), .mul_x(mul_x), .mul_y(mul_y),
    .mul_n(mul_n), .mul_result(mul_result), .mul_finish(mul_finish),
    .exp_result(exp_result), .exp_done(exp_done), .exp_busy(exp_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [W-1:0] res;
    int           pulses;
  } exp_t;
  exp_t sb_q[$];
  exp_t sb_item;

  task automatic check(string name, longint act, longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // x*y*R^-1 mod 187 with R=256
  function automatic logic [W-1:0] mont(logic [W:0] x, logic [W:0] y);
    longint rinv = 0;
    for (int i = 1; i < 187; i++) if (((256 * i) % 187) == 1) rinv = i;
    return W'((longint'(x) * longint'(y) * rinv) % 187);
  endfunction

  // Behavioural multiplier: upper guard bits set to junk so discarding them matters
  logic       stall = 1'b0;
  logic       busy_m;
  int         dly;
  logic [W:0] xs, ys;
  always @(posedge clk or posedge mul_rst) begin
    if (mul_rst) begin
      mul_finish <= 1'b0;
      mul_result <= '0;
      busy_m     <= 1'b0;
      dly        <= 0;
    end else if (mul_clr) begin
      mul_finish <= 1'b0;
      busy_m     <= 1'b0;
    end else if (mul_start) begin
      xs     <= mul_x;
      ys     <= mul_y;
      dly    <= int'($urandom_range(1, 20));
      busy_m <= 1'b1;
    end else if (busy_m && !stall) begin
      if (dly <= 1) begin
        mul_finish <= 1'b1;
        mul_result <= {2'b11, mont(xs, ys)};
        busy_m     <= 1'b0;
      end else begin
        dly <= dly - 1;
      end
    end
  end

  // Monitor: counts mul_start pulses per run and scores each completion
  int   pulse_total = 0;
  int   start_cnt = 0;
  logic busy_d = 1'b0;
  logic done_d = 1'b0;
  always @(negedge clk) begin
    if (mul_start) pulse_total++;
    if (exp_busy && !busy_d) start_cnt = pulse_total;
    if (exp_done && !done_d) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=%0d required=none", exp_result);
      end else begin
        sb_item = sb_q.pop_front();
        check("exp_result", longint'(exp_result), longint'(sb_item.res));
        check("mul_start_pulses", longint'(pulse_total - start_cnt), longint'(sb_item.pulses));
      end
    end
    busy_d = exp_busy;
    done_d = exp_done;
  end

  task automatic start_run(logic [W-1:0] ev, logic [W-1:0] res, int pulses, bit push);
    @(posedge clk); #1;
    e = ev;
    exp_start = 1'b1;
    if (push) sb_q.push_back('{res, pulses});
    @(posedge clk); #1;
    exp_start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (exp_done) break;
    end
    check("exp_done_reached", longint'(exp_done), 1);
  endtask

  task automatic wait_mul_start();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mul_start) break;
    end
    check("mul_start_seen", longint'(mul_start), 1);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_mul_clr"}, longint'(mul_clr), 1);
    check({tag, "_mul_start"}, longint'(mul_start), 0);
    check({tag, "_exp_busy"}, longint'(exp_busy), 0);
    check({tag, "_exp_done"}, longint'(exp_done), 0);
    check({tag, "_mul_x"}, longint'(mul_x), 0);
    check({tag, "_mul_y"}, longint'(mul_y), 0);
    check({tag, "_mul_n"}, longint'(mul_n), 0);
    check({tag, "_exp_result"}, longint'(exp_result), 0);
  endtask

  logic [W:0] hx, hy;
  int         extra, changed;

  initial begin
    mul_rst = 1'b1;
    exp_start = 1'b0;
    base_m = 8'd158;
    one_m = 8'd69;
    n = 8'd187;
    e = 8'd0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    mul_rst = 1'b0;

    // Basic exponents: 5^3=125, 5^0=1, 5^1=5, 5^255 mod 187 = 177
    start_run(8'd3, 8'd125, 11, 1'b1);
    wait_done();
    check("mul_n_copy", longint'(mul_n), 187);
    start_run(8'd0, 8'd1, 9, 1'b1);
    wait_done();
    start_run(8'd1, 8'd5, 10, 1'b1);
    wait_done();
    start_run(8'hFF, 8'd177, 17, 1'b1);
    wait_done();

    // Stall in WAIT for 500 cycles with a stray exp_start in the middle
    stall = 1'b1;
    start_run(8'd3, 8'd125, 11, 1'b1);
    wait_mul_start();
    @(negedge clk);
    hx = mul_x;
    hy = mul_y;
    extra = 0;
    changed = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (mul_start) extra++;
      if ((mul_x != hx) || (mul_y != hy)) changed++;
      if (i == 100) begin
        e = 8'd0;
        exp_start = 1'b1;
      end else begin
        exp_start = 1'b0;
      end
    end
    check("stall_extra_start", longint'(extra), 0);
    check("stall_xy_changed", longint'(changed), 0);
    check("stall_busy", longint'(exp_busy), 1);
    stall = 1'b0;
    wait_done();

    // Restart from DONE: done drops at once, previous result held
    start_run(8'd1, 8'd5, 10, 1'b1);
    check("restart_done_low", longint'(exp_done), 0);
    check("restart_busy", longint'(exp_busy), 1);
    check("restart_result_held", longint'(exp_result), 125);
    wait_done();

    // Reset in the middle of WAIT
    stall = 1'b1;
    start_run(8'hFF, 8'd0, 0, 1'b0);
    wait_mul_start();
    @(negedge clk);
    @(negedge clk);
    mul_rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    mul_rst = 1'b0;
    stall = 1'b0;
    start_run(8'd3, 8'd125, 11, 1'b1);
    wait_done();

    repeat (3) @(negedge clk);
    check("scoreboard_drained", longint'(sb_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
